// File: rtl/serial_magnitude_comparator_pkg.sv
// rtl/serial_magnitude_comparator_pkg.sv - shared encodings for the serial magnitude comparator
//
// Purpose: one-hot result encoding and FSM state encoding shared by the
//          comparator top level and its bench.
// Ports:   none (package).
package serial_magnitude_comparator_pkg;

    // One-hot {gt,eq,lt} result; all-zero means no result is available.
    localparam logic [2:0] COMP_GT   = 3'b100;
    localparam logic [2:0] COMP_EQ   = 3'b010;
    localparam logic [2:0] COMP_LT   = 3'b001;
    localparam logic [2:0] COMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_magnitude_comparator_chunk_compare.sv
// rtl/serial_magnitude_comparator_chunk_compare.sv - combinational W-bit unsigned chunk compare
//
// Purpose: compares one W-bit slice of each operand; equality is the case
//          where neither gt nor lt is asserted.
// Ports:   a, b  - W-bit unsigned chunks
//          gt    - a > b
//          lt    - a < b
module chunk_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - multi-cycle N-bit magnitude comparator, W bits per cycle
//
// Purpose: latches x/y on an accepted start and compares them one W-bit chunk
//          per clock, most significant chunk first. The one-hot result is held
//          until the next accepted start or reset.
// Ports:   clk         - clock, rising edge
//          rst         - synchronous active-high reset
//          start       - operation request, accepted when busy is low
//          signed_mode - 1 = two's-complement compare, sampled with start
//          x, y        - N-bit operands, sampled with start
//          busy        - high while chunks are being compared
//          done        - one-cycle pulse when comp becomes valid
//          comp        - {gt,eq,lt} result, 000 when no result
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int N          = 16,
    parameter int W          = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [2:0]   comp
);

    localparam int C     = N / W;
    localparam int IDX_W = (C > 1) ? $clog2(C) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C - 1);
    // Flipping the sign bit maps two's complement onto offset binary, so a
    // plain unsigned compare then orders signed values correctly.
    localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

    generate
        if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
            $error("serial_magnitude_comparator: need N >= 1, 1 <= W <= N and N %% W == 0");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic             accept;

    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             sticky;
    logic             sticky_gt;

    logic [W-1:0]     a_chunk;
    logic [W-1:0]     b_chunk;
    logic             c_gt;
    logic             c_lt;
    logic             differs;
    logic             finish;
    logic [2:0]       result;

    assign a_chunk = a_q[idx*W +: W];
    assign b_chunk = b_q[idx*W +: W];

    chunk_compare #(
        .W (W)
    ) u_chunk_compare (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (c_gt),
        .lt (c_lt)
    );

    assign differs = c_gt | c_lt;
    assign finish  = ((EARLY_EXIT != 0) && differs) || (idx == '0);

    // The earliest (most significant) differing chunk decides the result;
    // in fixed-latency mode it was parked in the sticky flag while later,
    // less significant chunks were still being stepped.
    always_comb begin
        result = COMP_EQ;
        if (sticky) begin
            result = sticky_gt ? COMP_GT : COMP_LT;
        end else if (c_gt) begin
            result = COMP_GT;
        end else if (c_lt) begin
            result = COMP_LT;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                if (finish) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            sticky    <= 1'b0;
            sticky_gt <= 1'b0;
            comp      <= COMP_NONE;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q       <= x ^ (signed_mode ? MSB_MASK : '0);
                b_q       <= y ^ (signed_mode ? MSB_MASK : '0);
                idx       <= IDX_LAST;
                sticky    <= 1'b0;
                sticky_gt <= 1'b0;
                comp      <= COMP_NONE;
            end else if (state == RUN) begin
                if (finish) begin
                    comp <= result;
                end else begin
                    idx <= idx - 1'b1;
                    if (differs && !sticky) begin
                        sticky    <= 1'b1;
                        sticky_gt <= c_gt;
                    end
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for the serial magnitude comparator
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;

    typedef struct {
        logic [2:0] comp;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st0, st1;
    logic        sm;
    logic [15:0] x_bus, y_bus;
    logic        busy0, done0, busy1, done1;
    logic [2:0]  comp0, comp1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator #(.N(16), .W(4), .EARLY_EXIT(0)) u_fixed (
        .clk (clk), .rst (rst), .start (st0), .signed_mode (sm),
        .x (x_bus), .y (y_bus), .busy (busy0), .done (done0), .comp (comp0)
    );

    serial_magnitude_comparator #(.N(16), .W(4), .EARLY_EXIT(1)) u_early (
        .clk (clk), .rst (rst), .start (st1), .signed_mode (sm),
        .x (x_bus), .y (y_bus), .busy (busy1), .done (done1), .comp (comp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [2:0] comp_of(input int inst);
        return (inst == 0) ? comp0 : comp1;
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) st0 = v;
        else           st1 = v;
    endtask

    task automatic push(input int inst, input logic [2:0] c, input int at);
        exp_t item;
        item.comp = c;
        item.cyc  = at;
        if (inst == 0) q0.push_back(item);
        else           q1.push_back(item);
    endtask

    // Monitor: every done pulse pops one expected result and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) check("fixed spurious done", done0, 0);
            else begin
                e = q0.pop_front();
                check("fixed comp", comp0, e.comp);
                check("fixed done cycle", cyc, e.cyc);
            end
        end
        if (done1) begin
            if (q1.size() == 0) check("early spurious done", done1, 0);
            else begin
                e = q1.pop_front();
                check("early comp", comp1, e.comp);
                check("early done cycle", cyc, e.cyc);
            end
        end
    end

    // One operation: start accepted at edge E, busy expected high after edges
    // E..E+lat-1 and low from E+lat, result held one cycle past done.
    task automatic issue(input int inst, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] e, input int lat,
                         input bit chg_ops, input bit pulse);
        @(negedge clk);
        x_bus = a;
        y_bus = b;
        sm    = s;
        set_start(inst, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(inst, 1'b0);
        push(inst, e, cyc + lat);
        check("comp cleared on start", comp_of(inst), COMP_NONE);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            check("busy profile", busy_of(inst), (k < lat));
            if (k == 0 && chg_ops) begin
                x_bus = 16'h0000;
                y_bus = 16'hFFFF;
                sm    = ~s;
            end
            if (k == 0 && pulse) set_start(inst, 1'b1);
            if (k == 1 && pulse) set_start(inst, 1'b0);
        end
        @(negedge clk);
        check("comp held in idle", comp_of(inst), e);
    endtask

    initial begin
        rst   = 1'b1;
        st0   = 1'b0;
        st1   = 1'b0;
        sm    = 1'b0;
        x_bus = '0;
        y_bus = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {busy1, busy0}, 0);
        check("reset done", {done1, done0}, 0);
        check("reset comp", {comp1, comp0}, 0);
        rst = 1'b0;

        // Fixed latency: every operation takes C = 4 edges.
        issue(0, 16'h1234, 16'h1235, 1'b0, COMP_LT, 4, 0, 0);
        issue(0, 16'hABCD, 16'hABCD, 1'b0, COMP_EQ, 4, 1, 0);
        issue(0, 16'hFFFF, 16'h0001, 1'b1, COMP_LT, 4, 0, 0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, COMP_GT, 4, 0, 0);
        issue(0, 16'h2F00, 16'h1FFF, 1'b0, COMP_GT, 4, 0, 0);
        issue(0, 16'h8000, 16'hFFFF, 1'b1, COMP_LT, 4, 0, 0);
        issue(0, 16'h00FF, 16'h0F00, 1'b0, COMP_LT, 4, 0, 1);

        // Early exit: latency is the 1-based position of the first differing chunk.
        issue(1, 16'h8000, 16'h0000, 1'b0, COMP_GT, 1, 0, 0);
        issue(1, 16'h1230, 16'h1231, 1'b0, COMP_LT, 4, 0, 0);
        issue(1, 16'hABCD, 16'hABCD, 1'b0, COMP_EQ, 4, 1, 0);
        issue(1, 16'hFFFF, 16'h0001, 1'b1, COMP_LT, 1, 0, 0);
        issue(1, 16'hFFFF, 16'h0001, 1'b0, COMP_GT, 1, 0, 0);
        issue(1, 16'h1234, 16'h1335, 1'b0, COMP_LT, 2, 0, 0);
        issue(1, 16'h2F00, 16'h1FFF, 1'b0, COMP_GT, 1, 0, 0);
        issue(1, 16'h8000, 16'hFFFF, 1'b1, COMP_LT, 1, 0, 0);
        issue(1, 16'h0010, 16'h0020, 1'b0, COMP_LT, 3, 0, 1);

        // Back-to-back: start held in the done cycle launches the next operation.
        @(negedge clk);
        x_bus = 16'h0001;
        y_bus = 16'h0002;
        sm    = 1'b0;
        st0   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0;
        push(0, COMP_LT, cyc + 4);
        repeat (4) @(negedge clk);
        check("b2b first done", done0, 1);
        x_bus = 16'h00F0;
        y_bus = 16'h000F;
        st0   = 1'b1;
        push(0, COMP_GT, cyc + 5);
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0;
        check("b2b second busy", busy0, 1);
        check("b2b comp cleared", comp0, COMP_NONE);
        repeat (4) @(negedge clk);
        check("b2b second done", done0, 1);
        @(negedge clk);

        // Reset mid-run aborts without a done pulse.
        x_bus = 16'h1111;
        y_bus = 16'h2222;
        st0   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy0, 0);
        check("abort done", done0, 0);
        check("abort comp", comp0, COMP_NONE);
        repeat (6) @(negedge clk);
        check("abort stays idle", busy0, 0);
        issue(0, 16'h0005, 16'h0003, 1'b0, COMP_GT, 4, 0, 0);

        repeat (3) @(negedge clk);
        check("fixed queue drained", q0.size(), 0);
        check("early queue drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
